// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared types and encodings for the RV32I multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_JLINK  = 4'd13,
    S_LUI    = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_R     = 2'd1,
    CLS_I     = 2'd2,
    CLS_BR    = 2'd3
  } op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
    logic [2:0] imm;
    imm = IMM_I;
    case (opcode)
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_JAL:            imm = IMM_J;
      OP_LUI, OP_AUIPC:  imm = IMM_U;
      default:           imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Controller <-> datapath/memory signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface multicycle_control_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
);
  logic [31:0]           instr;
  logic                  eq;
  logic                  lt;
  logic                  ltu;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_write;
  logic                  adr_src;
  logic                  ir_write;
  logic                  pc_write;
  logic                  reg_write;
  logic                  pc_lsb_clr;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [2:0]            imm_src;
  logic [1:0]            result_src;
  logic                  retire;
  logic [CNT_W-1:0]      instret;
  logic                  illegal;

  modport master (
    input  instr, eq, lt, ltu, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           pc_lsb_clr, alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
           retire, instret, illegal
  );

  modport slave (
    output instr, eq, lt, ltu, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           pc_lsb_clr, alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
           retire, instret, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Brief    : Combinational ALU-operation and branch-condition decode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  op_class_t   op_class_i,
  input  logic [2:0]  funct3_i,
  input  logic        bit30_i,
  input  logic        eq_i,
  input  logic        lt_i,
  input  logic        ltu_i,
  output logic [3:0]  alu_ctrl_o,
  output logic        branch_taken_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    if (op_class_i == CLS_BR) begin
      alu_ctrl_o = ALU_SUB;
    end else if (op_class_i == CLS_R || op_class_i == CLS_I) begin
      case (funct3_i)
        // Immediate forms carry imm[10] in bit 30, so only srai may honour it.
        3'b000:  alu_ctrl_o = (op_class_i == CLS_R && bit30_i) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl_o = ALU_SLL;
        3'b010:  alu_ctrl_o = ALU_SLT;
        3'b011:  alu_ctrl_o = ALU_SLTU;
        3'b100:  alu_ctrl_o = ALU_XOR;
        3'b101:  alu_ctrl_o = bit30_i ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl_o = ALU_OR;
        3'b111:  alu_ctrl_o = ALU_AND;
        default: alu_ctrl_o = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    branch_taken_o = 1'b0;
    if (op_class_i == CLS_BR) begin
      case (funct3_i)
        3'b000:  branch_taken_o = eq_i;
        3'b001:  branch_taken_o = !eq_i;
        3'b100:  branch_taken_o = lt_i;
        3'b101:  branch_taken_o = !lt_i;
        3'b110:  branch_taken_o = ltu_i;
        3'b111:  branch_taken_o = !ltu_i;
        default: branch_taken_o = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : RV32I multi-cycle sequencer; ILLEGAL_TRAP_EN selects trap-on-
//            unknown-opcode instead of NOP retirement.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_bit30;
  logic       w_unused_instr;
  op_class_t  w_class;
  logic [3:0] w_dec_alu;
  logic       w_taken;

  logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
  logic       w_reg_write, w_pc_lsb_clr, w_retire;
  logic [1:0] w_src_a, w_src_b, w_res;
  logic [3:0] w_alu;
  logic [2:0] w_imm;

  assign w_opcode       = bus.instr[6:0];
  assign w_funct3       = bus.instr[14:12];
  assign w_bit30        = bus.instr[30];
  assign w_unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  always_comb begin
    case (state_q)
      S_EXECR:  w_class = CLS_R;
      S_EXECI:  w_class = CLS_I;
      S_BRANCH: w_class = CLS_BR;
      default:  w_class = CLS_OTHER;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op_class_i     (w_class),
    .funct3_i       (w_funct3),
    .bit30_i        (w_bit30),
    .eq_i           (bus.eq),
    .lt_i           (bus.lt),
    .ltu_i          (bus.ltu),
    .alu_ctrl_o     (w_dec_alu),
    .branch_taken_o (w_taken)
  );

  // Outputs decode from the state register; only FETCH/MEMRD/MEMWR look at
  // mem_ready and only BRANCH looks at the comparator flags.
  always_comb begin
    state_d      = state_q;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_lsb_clr = 1'b0;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_alu        = ALU_ADD;
    w_imm        = IMM_I;
    w_res        = RES_ALUOUT;
    w_retire     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_src_b   = SRCB_FOUR;
        w_res     = RES_ALU;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        w_imm   = imm_src_of(w_opcode);
        case (w_opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d  = S_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
        w_imm   = imm_src_of(w_opcode);
        state_d = (w_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        w_res       = RES_RDATA;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_RS2;
        w_alu   = w_dec_alu;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
        w_imm   = imm_src_of(w_opcode);
        w_alu   = w_dec_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a    = SRCA_RS1;
        w_src_b    = SRCB_RS2;
        w_alu      = w_dec_alu;
        w_pc_write = w_taken;
        w_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        w_src_a    = SRCA_OLDPC;
        w_src_b    = SRCB_FOUR;
        w_pc_write = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_IMM;
        w_imm        = imm_src_of(w_opcode);
        w_res        = RES_ALU;
        w_pc_write   = 1'b1;
        w_pc_lsb_clr = 1'b1;
        state_d      = S_JLINK;
      end
      S_JLINK: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        w_imm       = imm_src_of(w_opcode);
        w_res       = RES_IMM;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.illegal = 1'b0;
`endif

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_write  = w_mem_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.pc_lsb_clr = w_pc_lsb_clr;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alu_ctrl   = ALU_CTRL_W'(w_alu);
  assign bus.imm_src    = w_imm;
  assign bus.result_src = w_res;
  assign bus.retire     = w_retire;
  assign bus.instret    = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed-vector bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_CTRL_W(4), .CNT_W(32)) bus ();

  multicycle_control #(.ALU_CTRL_W(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Packed order: mem_req mem_write adr_src ir_write pc_write reg_write
  // pc_lsb_clr alu_src_a alu_src_b alu_ctrl imm_src result_src retire
  function automatic logic [20:0] mk(input logic mreq, mwr, adr, irw, pcw, rw, lsb,
                                     input logic [1:0] a, b, input logic [3:0] alu,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic ret);
    return {mreq, mwr, adr, irw, pcw, rw, lsb, a, b, alu, imm, res, ret};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.pc_lsb_clr, bus.alu_src_a, bus.alu_src_b,
            bus.alu_ctrl, bus.imm_src, bus.result_src, bus.retire};
  endfunction

  localparam logic [20:0] ZERO   = 21'd0;
  localparam logic [20:0] F_WAIT = {1'b1, 6'b0, 2'b00, 2'b10, 4'd0, 3'd0, 2'b10, 1'b0};
  localparam logic [20:0] F_GO   = {1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 4'd0, 3'd0, 2'b10, 1'b0};
  localparam logic [20:0] WB     = {5'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b00, 1'b1};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic cc(input string tag, input logic [20:0] e);
    #1;
    chk(tag, 64'(obs()), 64'(e));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] ir);
    nxt();
    bus.instr     = ir;
    bus.mem_ready = 1'b1;
    cc(tag, F_GO);
  endtask

  function automatic logic [20:0] dec(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, imm, 2'b00, 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr = 32'h0; bus.eq = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.mem_ready = 1'b0;
    #12;
    cc("reset_outputs", ZERO);
    chk("reset_instret", 64'(bus.instret), 64'd0);
    chk("reset_illegal", 64'(bus.illegal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cc("idle", ZERO);

    // add x3,x1,x2 with one FETCH wait
    nxt(); bus.instr = 32'h002081B3; bus.mem_ready = 1'b0;
    cc("fetch_wait", F_WAIT);
    nxt(); bus.mem_ready = 1'b1;
    cc("fetch_go", F_GO);
    nxt(); cc("add_decode", dec(3'd0));
    nxt(); cc("add_execr", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("add_aluwb", WB);

    do_fetch("sub_fetch", 32'h402081B3);
    chk("instret_add", 64'(bus.instret), 64'd1);
    nxt(); cc("sub_decode", dec(3'd0));
    nxt(); cc("sub_execr", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'd1, 3'd0, 2'b00, 0));
    nxt(); cc("sub_aluwb", WB);

    do_fetch("srai_fetch", 32'h4030D093);
    nxt(); cc("srai_decode", dec(3'd0));
    nxt(); cc("srai_execi", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd7, 3'd0, 2'b00, 0));
    nxt(); cc("srai_aluwb", WB);

    do_fetch("addi_fetch", 32'h40008093);
    nxt(); cc("addi_decode", dec(3'd0));
    nxt(); cc("addi_bit30_execi", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("addi_aluwb", WB);

    // lw with two wait cycles in MEMRD
    do_fetch("lw_fetch", 32'h0080A283);
    chk("instret_alu4", 64'(bus.instret), 64'd4);
    nxt(); cc("lw_decode", dec(3'd0));
    nxt(); cc("lw_memadr", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 3'd0, 2'b00, 0));
    nxt(); bus.mem_ready = 1'b0;
    cc("lw_memrd_wait1", mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("lw_memrd_wait2", mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b00, 0));
    nxt(); bus.mem_ready = 1'b1;
    cc("lw_memrd_go", mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("lw_memwb", mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b01, 1));

    // beq taken / not taken, bltu taken
    do_fetch("beq1_fetch", 32'h00208463);
    chk("instret_lw", 64'(bus.instret), 64'd5);
    nxt(); cc("beq1_decode", dec(3'd2));
    nxt(); bus.eq = 1'b1;
    cc("beq_taken", mk(0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 4'd1, 3'd0, 2'b00, 1));
    do_fetch("beq0_fetch", 32'h00208463);
    nxt(); cc("beq0_decode", dec(3'd2));
    nxt(); bus.eq = 1'b0;
    cc("beq_not_taken", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'd1, 3'd0, 2'b00, 1));
    do_fetch("bltu_fetch", 32'h0020E463);
    nxt(); cc("bltu_decode", dec(3'd2));
    nxt(); bus.ltu = 1'b1;
    cc("bltu_taken", mk(0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 4'd1, 3'd0, 2'b00, 1));
    bus.ltu = 1'b0;

    // jal, jalr, lui, auipc
    do_fetch("jal_fetch", 32'h008000EF);
    chk("instret_br", 64'(bus.instret), 64'd8);
    nxt(); cc("jal_decode", dec(3'd3));
    nxt(); cc("jal_exec", mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("jal_aluwb", WB);
    do_fetch("jalr_fetch", 32'h000080E7);
    nxt(); cc("jalr_decode", dec(3'd0));
    nxt(); cc("jalr_exec", mk(0, 0, 0, 0, 1, 0, 1, 2'b10, 2'b01, 4'd0, 3'd0, 2'b10, 0));
    nxt(); cc("jalr_jlink", mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'd0, 3'd0, 2'b00, 0));
    nxt(); cc("jalr_aluwb", WB);
    do_fetch("lui_fetch", 32'h123450B7);
    nxt(); cc("lui_decode", dec(3'd4));
    nxt(); cc("lui_wb", mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 3'd4, 2'b11, 1));
    do_fetch("auipc_fetch", 32'h12345097);
    nxt(); cc("auipc_decode", dec(3'd4));
    nxt(); cc("auipc_aluwb", WB);

    // sw, reset pulled while MEMWR waits
    do_fetch("sw_fetch", 32'h0020A023);
    chk("instret_jumps", 64'(bus.instret), 64'd12);
    nxt(); cc("sw_decode", dec(3'd1));
    nxt(); cc("sw_memadr", mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 3'd1, 2'b00, 0));
    nxt(); bus.mem_ready = 1'b0;
    cc("sw_memwr_wait", mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 3'd0, 2'b00, 0));
    #1; rst_n = 1'b0;
    cc("rst_mid_memwr", ZERO);
    chk("rst_instret", 64'(bus.instret), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cc("idle_after_rst", ZERO);
    do_fetch("fetch_after_rst", 32'h00000000);

    // unknown opcode
`ifdef ILLEGAL_TRAP_EN
    nxt(); cc("illegal_decode", dec(3'd0));
    chk("illegal_pre_trap", 64'(bus.illegal), 64'd0);
    nxt(); cc("trap_outputs", ZERO);
    chk("trap_illegal", 64'(bus.illegal), 64'd1);
    nxt(); nxt(); cc("trap_held", ZERO);
    chk("trap_illegal_held", 64'(bus.illegal), 64'd1);
    chk("trap_instret", 64'(bus.instret), 64'd0);
`else
    nxt(); cc("nop_decode", mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 3'd0, 2'b00, 1));
    do_fetch("nop_next_fetch", 32'h002081B3);
    chk("nop_instret", 64'(bus.instret), 64'd1);
    chk("nop_illegal", 64'(bus.illegal), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
